// File: rtl/switch_debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package switch_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b10,
    WAIT_LO = 2'b11
  } state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF           = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
module sync_2ff (
  input  logic Clk,
  input  logic Resetn,
  input  logic i_async,
  output logic o_sync
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
    end
  end

  assign o_sync = r_s2;

endmodule

// File: rtl/switch_debounce.sv
// Debounces a raw switch into a clean level D with optional Rise/Fall pulses.
// Pulse outputs are built only when SWITCH_DEBOUNCE_EDGE_EN is defined.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic Sw_in,
  output logic D,
  output logic Rise,
  output logic Fall
);

  localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;

  if (CNT_W < 2 || CNT_W > 32 || DEBOUNCE_CYCLES < 2 ||
      64'(DEBOUNCE_CYCLES) > CntMax) begin : g_param_check
    $error("switch_debounce: DEBOUNCE_CYCLES must be in 2..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic             w_sync;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_d;
  logic             w_d_next;

  sync_2ff u_sync (
    .Clk     (Clk),
    .Resetn  (Resetn),
    .i_async (Sw_in),
    .o_sync  (w_sync)
  );

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
      r_d     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_d     <= w_d_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_d_next     = r_d;
    case (r_state)
      IDLE_LO: begin
        if (w_sync) begin
          w_state_next = WAIT_HI;
          w_cnt_next   = CntOne;
        end else begin
          w_cnt_next = '0;
        end
      end
      WAIT_HI: begin
        // Any return to the old level discards the whole count.
        if (!w_sync) begin
          w_state_next = IDLE_LO;
          w_cnt_next   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_next = IDLE_HI;
          w_cnt_next   = '0;
          w_d_next     = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CntOne;
        end
      end
      IDLE_HI: begin
        if (!w_sync) begin
          w_state_next = WAIT_LO;
          w_cnt_next   = CntOne;
        end else begin
          w_cnt_next = '0;
        end
      end
      WAIT_LO: begin
        if (w_sync) begin
          w_state_next = IDLE_HI;
          w_cnt_next   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_next = IDLE_LO;
          w_cnt_next   = '0;
          w_d_next     = 1'b0;
        end else begin
          w_cnt_next = r_cnt + CntOne;
        end
      end
      default: begin
        w_state_next = IDLE_LO;
        w_cnt_next   = '0;
        w_d_next     = 1'b0;
      end
    endcase
  end

  assign D = r_d;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic r_rise;
  logic r_fall;

  // Pulses coincide with the registered D update, so they are mutually exclusive.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_d_next & ~r_d;
      r_fall <= ~w_d_next & r_d;
    end
  end

  assign Rise = r_rise;
  assign Fall = r_fall;
`else
  assign Rise = 1'b0;
  assign Fall = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce using a per-edge expected-output scoreboard.
module tb_switch_debounce;

  localparam int Dc = 4;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  localparam int PulseExp = 1;
`else
  localparam int PulseExp = 0;
`endif

  typedef struct packed {
    logic d;
    logic rise;
    logic fall;
  } exp_t;

  logic Clk;
  logic Resetn;
  logic Sw_in;
  logic D;
  logic Rise;
  logic Fall;

  int   n_pass;
  int   n_total;
  exp_t sb_q[$];

  switch_debounce dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .Sw_in  (Sw_in),
    .D      (D),
    .Rise   (Rise),
    .Fall   (Fall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: D flips once the synchronized input has differed from D for Dc edges in a row.
  initial begin
    logic m_s1;
    logic m_s2;
    logic m_d;
    logic sync;
    int   run;
    exp_t e;
    m_s1 = 1'b0; m_s2 = 1'b0; m_d = 1'b0; run = 0;
    forever begin
      @(posedge Clk or negedge Resetn);
      if (!Resetn) begin
        m_s1 = 1'b0; m_s2 = 1'b0; m_d = 1'b0; run = 0;
      end else begin
        sync = m_s2;
        m_s2 = m_s1;
        m_s1 = Sw_in;
        e = '0;
        if (sync != m_d) begin
          run++;
          if (run == Dc) begin
            m_d = sync;
            run = 0;
            e.rise = (PulseExp == 1) &&  sync;
            e.fall = (PulseExp == 1) && !sync;
          end
        end else begin
          run = 0;
        end
        e.d = m_d;
        sb_q.push_back(e);
      end
    end
  end

  task automatic test_reset();
    exp_t e;
    Resetn = 1'b0;
    Sw_in  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      n_total++;
      if ({D, Rise, Fall} !== 3'b000)
        $display("FAIL reset_hold cyc %0d: D/Rise/Fall=%b%b%b expected 000", i, D, Rise, Fall);
      else n_pass++;
    end
    #2 Resetn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 9) Sw_in = 1'b0;
      @(negedge Clk);
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL reset_trace cyc %0d: no expected entry", i);
      end else begin
        e = sb_q.pop_front();
        if ({D, Rise, Fall} !== {e.d, e.rise, e.fall})
          $display("FAIL reset_trace cyc %0d: D/Rise/Fall=%b%b%b expected %b%b%b",
                   i, D, Rise, Fall, e.d, e.rise, e.fall);
        else n_pass++;
      end
      if (i == 1) begin
        n_total++;
        if (D !== 1'b0) $display("FAIL first_edge_after_reset: D=%b expected 0", D);
        else n_pass++;
      end
    end
  endtask

  task automatic test_clean_edges();
    exp_t e;
    for (int phase = 0; phase < 2; phase++) begin
      int commit_at;
      int rises;
      int falls;
      logic target;
      commit_at = 0; rises = 0; falls = 0;
      target = (phase == 0);
      Sw_in = target;
      for (int i = 1; i <= 10; i++) begin
        @(negedge Clk);
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL clean_trace ph%0d cyc %0d: no expected entry", phase, i);
        end else begin
          e = sb_q.pop_front();
          if ({D, Rise, Fall} !== {e.d, e.rise, e.fall})
            $display("FAIL clean_trace ph%0d cyc %0d: D/Rise/Fall=%b%b%b expected %b%b%b",
                     phase, i, D, Rise, Fall, e.d, e.rise, e.fall);
          else n_pass++;
        end
        if (D === target && commit_at == 0) commit_at = i;
        if (Rise === 1'b1) rises++;
        if (Fall === 1'b1) falls++;
      end
      n_total++;
      if (commit_at != 6)
        $display("FAIL clean_latency ph%0d: D settled after negedge %0d expected 6", phase, commit_at);
      else n_pass++;
      n_total++;
      if (rises != ((phase == 0) ? PulseExp : 0) || falls != ((phase == 1) ? PulseExp : 0))
        $display("FAIL clean_pulses ph%0d: rises=%0d falls=%0d", phase, rises, falls);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    int   commit_at;
    int   rises;
    commit_at = 0; rises = 0;
    fork
      begin
        #2  Sw_in = 1'b1;
        #15 Sw_in = 1'b0;
        #15 Sw_in = 1'b1;
        #15 Sw_in = 1'b0;
        #15 Sw_in = 1'b1;
      end
      begin
        for (int i = 1; i <= 16; i++) begin
          @(negedge Clk);
          n_total++;
          if (sb_q.size() == 0) begin
            $display("FAIL bounce_trace cyc %0d: no expected entry", i);
          end else begin
            e = sb_q.pop_front();
            if ({D, Rise, Fall} !== {e.d, e.rise, e.fall})
              $display("FAIL bounce_trace cyc %0d: D/Rise/Fall=%b%b%b expected %b%b%b",
                       i, D, Rise, Fall, e.d, e.rise, e.fall);
            else n_pass++;
          end
          if (D === 1'b1 && commit_at == 0) commit_at = i;
          if (Rise === 1'b1) rises++;
        end
      end
    join
    n_total++;
    if (commit_at != 12) $display("FAIL bounce_latency: D rose after negedge %0d expected 12", commit_at);
    else n_pass++;
    n_total++;
    if (rises != PulseExp) $display("FAIL bounce_rise_count: got %0d expected %0d", rises, PulseExp);
    else n_pass++;
    Sw_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk);
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL bounce_return cyc %0d: no expected entry", i);
      end else begin
        e = sb_q.pop_front();
        if ({D, Rise, Fall} !== {e.d, e.rise, e.fall})
          $display("FAIL bounce_return cyc %0d: D/Rise/Fall=%b%b%b expected %b%b%b",
                   i, D, Rise, Fall, e.d, e.rise, e.fall);
        else n_pass++;
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    int   highs;
    highs = 0;
    Sw_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (i == 2) Sw_in = 1'b0;
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL glitch_trace cyc %0d: no expected entry", i);
      end else begin
        e = sb_q.pop_front();
        if ({D, Rise, Fall} !== {e.d, e.rise, e.fall})
          $display("FAIL glitch_trace cyc %0d: D/Rise/Fall=%b%b%b expected %b%b%b",
                   i, D, Rise, Fall, e.d, e.rise, e.fall);
        else n_pass++;
      end
      if (D !== 1'b0 || Rise !== 1'b0) highs++;
    end
    n_total++;
    if (highs != 0) $display("FAIL glitch_ignored: D or Rise high on %0d cycles, expected 0", highs);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    int   commit_at;
    commit_at = 0;
    Sw_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clk);
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL midwait_pre cyc %0d: no expected entry", i);
      end else begin
        e = sb_q.pop_front();
        if ({D, Rise, Fall} !== {e.d, e.rise, e.fall})
          $display("FAIL midwait_pre cyc %0d: D/Rise/Fall=%b%b%b expected %b%b%b",
                   i, D, Rise, Fall, e.d, e.rise, e.fall);
        else n_pass++;
      end
    end
    #2 Resetn = 1'b0;
    #1;
    n_total++;
    if ({D, Rise, Fall} !== 3'b000)
      $display("FAIL midwait_async_reset: D/Rise/Fall=%b%b%b expected 000", D, Rise, Fall);
    else n_pass++;
    @(negedge Clk);
    #2 Resetn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL midwait_trace cyc %0d: no expected entry", i);
      end else begin
        e = sb_q.pop_front();
        if ({D, Rise, Fall} !== {e.d, e.rise, e.fall})
          $display("FAIL midwait_trace cyc %0d: D/Rise/Fall=%b%b%b expected %b%b%b",
                   i, D, Rise, Fall, e.d, e.rise, e.fall);
        else n_pass++;
      end
      if (D === 1'b1 && commit_at == 0) commit_at = i;
    end
    n_total++;
    if (commit_at != 6)
      $display("FAIL midwait_latency: D rose after negedge %0d expected 6", commit_at);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    Resetn  = 1'b0;
    Sw_in   = 1'b0;
    test_reset();
    test_clean_edges();
    test_bounce();
    test_glitch();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
